// File: rtl/btn_irq_pkg.sv
// Shared definitions for the button interrupt controller.
//   - default sizing constants for NUM_BTN and DEB_CYCLES
//   - grant FSM state encoding
//   - id_width(): width of a button index, never less than one bit
package btn_irq_pkg;

    localparam int DEF_NUM_BTN    = 4;
    localparam int DEF_DEB_CYCLES = 1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } irq_state_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_irq_ctrl_if.sv
// CPU-side register/interrupt bundle of the button interrupt controller.
//   irq_en              CPU -> ctrl  per-button interrupt enable
//   irq_ack             CPU -> ctrl  one-cycle pulse retiring the current grant
//   ovr_clr             CPU -> ctrl  one-cycle pulse clearing all overrun flags
//   irq                 ctrl -> CPU  level interrupt
//   irq_id              ctrl -> CPU  granted button index, valid while irq=1
//   pend                ctrl -> CPU  pending request vector
//   btn_state           ctrl -> CPU  debounced pressed state
//   overrun             ctrl -> CPU  sticky "pressed again while pending"
//   btn_interrupt_debug ctrl -> CPU  copy of pend for the debug bus
interface btn_irq_ctrl_if #(
    parameter int NUM_BTN = btn_irq_pkg::DEF_NUM_BTN
);
    import btn_irq_pkg::*;

    localparam int ID_W = id_width(NUM_BTN);

    logic [NUM_BTN-1:0] irq_en;
    logic               irq_ack;
    logic               ovr_clr;
    logic               irq;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] btn_state;
    logic [NUM_BTN-1:0] overrun;
    logic [NUM_BTN-1:0] btn_interrupt_debug;

    modport master (
        output irq_en, irq_ack, ovr_clr,
        input  irq, irq_id, pend, btn_state, overrun, btn_interrupt_debug
    );

    modport slave (
        input  irq_en, irq_ack, ovr_clr,
        output irq, irq_id, pend, btn_state, overrun, btn_interrupt_debug
    );

endinterface

// File: rtl/btn_debounce.sv
// Single-button front end: 2-flop synchroniser, polarity normalisation,
// stability counter and press-edge pulse.
//   sysclk     system clock
//   rst_n      asynchronous active-low reset
//   btn_raw    raw asynchronous pin
//   btn_state  debounced state, 1 = pressed
//   press      one-cycle pulse, registered, on a debounced 0->1 transition
module btn_debounce
    import btn_irq_pkg::*;
#(
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_state,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic             RELEASED = BTN_ACTIVE_LOW;

    logic             sync1_r;
    logic             sync2_r;
    logic             state_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pressed_s;
    logic             differ_s;
    logic             expire_s;

    // two-flop synchroniser; resets to the idle pin level so no false press
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= RELEASED;
            sync2_r <= RELEASED;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = BTN_ACTIVE_LOW ? ~sync2_r : sync2_r;
    assign differ_s  = pressed_s ^ state_r;
    // the DEB_CYCLES-th consecutive differing sample flips the state
    assign expire_s  = differ_s && (cnt_r == CNT_LAST);

    // stability counter, debounced state and registered press pulse
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            state_r <= 1'b0;
            press_r <= 1'b0;
        end else if (expire_s) begin
            cnt_r   <= '0;
            state_r <= ~state_r;
            press_r <= ~state_r;
        end else if (differ_s) begin
            cnt_r   <= cnt_r + CNT_ONE;
            press_r <= 1'b0;
        end else begin
            cnt_r   <= '0;
            press_r <= 1'b0;
        end
    end

    assign btn_state = state_r;
    assign press     = press_r;

endmodule

// File: rtl/btn_irq_ctrl.sv
// Button interrupt controller: debounces NUM_BTN buttons, latches press
// events as pending requests and grants them round-robin onto one level IRQ.
//   sysclk  system clock
//   rst_n   asynchronous active-low reset
//   btn     raw asynchronous button pins
//   bus     CPU-side bundle (enables, ack, overrun clear, irq/id, status)
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int NUM_BTN        = DEF_NUM_BTN,
    parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn,
    btn_irq_ctrl_if.slave      bus
);

    localparam int            ID_W     = id_width(NUM_BTN);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_BTN - 32'sd1);

    logic [NUM_BTN-1:0] state_s;
    logic [NUM_BTN-1:0] press_s;
    logic [NUM_BTN-1:0] set_s;
    logic [NUM_BTN-1:0] cand_s;
    logic [NUM_BTN-1:0] ack_clr_s;
    logic [NUM_BTN-1:0] pend_r;
    logic [NUM_BTN-1:0] overrun_r;
    logic               found_s;
    logic [ID_W-1:0]    pick_s;
    irq_state_e         state_r;
    irq_state_e         state_nxt_s;
    logic               irq_r;
    logic               irq_nxt_s;
    logic [ID_W-1:0]    irq_id_r;
    logic [ID_W-1:0]    irq_id_nxt_s;
    logic [ID_W-1:0]    last_grant_r;
    logic [ID_W-1:0]    last_grant_nxt_s;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        btn_debounce #(
            .DEB_CYCLES     (DEB_CYCLES),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_deb (
            .sysclk    (sysclk),
            .rst_n     (rst_n),
            .btn_raw   (btn[g]),
            .btn_state (state_s[g]),
            .press     (press_s[g])
        );
    end

    assign set_s   = press_s & bus.irq_en;
    assign cand_s  = pend_r & bus.irq_en;
    assign found_s = |cand_s;

    // round-robin pick: scan from farthest to nearest after last_grant so the
    // nearest eligible index is the one left standing
    always_comb begin
        pick_s = '0;
        for (int k = NUM_BTN; k >= 1; k--) begin
            if (cand_s[ID_W'((int'(last_grant_r) + k) % NUM_BTN)]) begin
                pick_s = ID_W'((int'(last_grant_r) + k) % NUM_BTN);
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // grant FSM state register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // grant FSM next state, irq/id next values and pend clear on ack
    always_comb begin
        state_nxt_s      = state_r;
        irq_nxt_s        = irq_r;
        irq_id_nxt_s     = irq_id_r;
        last_grant_nxt_s = last_grant_r;
        ack_clr_s        = '0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s  = ASSERT;
                    irq_nxt_s    = 1'b1;
                    irq_id_nxt_s = pick_s;
                end else begin
                    state_nxt_s  = IDLE;
                    irq_nxt_s    = 1'b0;
                end
            end
            ASSERT: begin
                // a grant is never withdrawn, even if its enable drops
                if (bus.irq_ack) begin
                    ack_clr_s[irq_id_r] = 1'b1;
                    last_grant_nxt_s    = irq_id_r;
                    irq_nxt_s           = 1'b0;
                    state_nxt_s         = GAP;
                end else begin
                    state_nxt_s         = ASSERT;
                end
            end
            GAP: begin
                // one forced low cycle so back-to-back grants are distinct
                state_nxt_s = IDLE;
                irq_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = IDLE;
                irq_nxt_s   = 1'b0;
            end
        endcase
    end

    // registered irq, irq_id and round-robin pointer
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r        <= 1'b0;
            irq_id_r     <= '0;
            last_grant_r <= LAST_IDX;
        end else begin
            irq_r        <= irq_nxt_s;
            irq_id_r     <= irq_id_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // pending and sticky overrun flags; a new press beats a same-cycle
    // ack (pend stays set, no overrun) and a same-cycle ovr_clr
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r    <= '0;
            overrun_r <= '0;
        end else begin
            pend_r    <= (pend_r & ~ack_clr_s) | set_s;
            overrun_r <= (bus.ovr_clr ? '0 : overrun_r) | (set_s & pend_r & ~ack_clr_s);
        end
    end

    assign bus.irq                 = irq_r;
    assign bus.irq_id              = irq_id_r;
    assign bus.pend                = pend_r;
    assign bus.btn_state           = state_s;
    assign bus.overrun             = overrun_r;
    assign bus.btn_interrupt_debug = pend_r;

endmodule

// File: doc/btn_irq_ctrl.md
Name: btn_irq_ctrl

Overview:
Button interrupt controller between the four board buttons and the Cortex-M0 SoC's single button IRQ line.
Synchronises and debounces each button, then detects press edges and latches them as pending requests.
Arbitrates pending requests round-robin onto one level IRQ with a source ID. The CPU retires each request with an ack pulse.
Also drives the 4-bit debug bus with the live pending vector.

Parameters:
NUM_BTN, 4, number of button inputs (ID width = clog2(NUM_BTN), min 1)
DEB_CYCLES, 1000000, stable cycles required before debounced state changes (20 ms at 50 MHz sysclk)
BTN_ACTIVE_LOW, 1, 1 = raw input 0 means pressed; 0 = raw input 1 means pressed

Ports:
sysclk  input  1  system clock (PLL soc clock domain)
rst_n  input  1  asynchronous active-low reset
btn  input  NUM_BTN  raw asynchronous button pins
irq_en  input  NUM_BTN  per-button enable, from CPU register (sysclk domain)
irq_ack  input  1  single-cycle pulse from CPU: retire current grant
ovr_clr  input  1  single-cycle pulse: clear all overrun flags
irq  output  1  level interrupt to CPU
irq_id  output  clog2(NUM_BTN)  index of granted button, valid while irq=1
pend  output  NUM_BTN  pending vector (status read)
btn_state  output  NUM_BTN  debounced pressed state (1 = pressed)
overrun  output  NUM_BTN  sticky: press arrived while already pending
btn_interrupt_debug  output  NUM_BTN  equals pend

Behaviour:
- Reset (async, rst_n=0): irq=0, irq_id=0, pend=0, btn_state=0, overrun=0, debug=0, sync flops = released level, debounce counters=0, FSM=IDLE, last_grant=NUM_BTN-1 (first grant starts search at 0).
- Sync: 2-flop synchroniser per button. Polarity normalised after sync (pressed=1).
- Debounce, per button: if synced != btn_state, counter increments; else counter clears. When counter = DEB_CYCLES-1 and still differs: btn_state toggles, counter clears. Glitches shorter than DEB_CYCLES never toggle btn_state. Counter width = clog2(DEB_CYCLES)+1, no wrap.
- Press event: one-cycle pulse when btn_state goes 0->1. Releases generate nothing.
- Latency: raw press held stable -> pend bit set on the (DEB_CYCLES+3)th sysclk rising edge.
- Pending set: on press event with irq_en[i]=1, pend[i]<=1. With irq_en[i]=0 the event is discarded.
- Overrun: press event with irq_en[i]=1 while pend[i]=1 and not being cleared that cycle -> overrun[i]<=1. Cleared only by ovr_clr. A set in the same cycle as ovr_clr wins.
- FSM IDLE: if any pend & irq_en, select the first such index after last_grant (wrap modulo NUM_BTN). Register irq_id, assert irq next cycle, go ASSERT.
- FSM ASSERT: irq=1, irq_id stable. On irq_ack: clear pend[irq_id], last_grant<=irq_id, irq<=0, go GAP.
  - irq_en[irq_id] dropping while in ASSERT does not retract irq; the grant waits for ack.
- FSM GAP: irq=0 for exactly one cycle, then IDLE (guarantees a visible deassert between back-to-back grants).
- irq_ack outside ASSERT is ignored.
- Same-cycle ack and new press on the granted bit: pend stays 1 (new request), no overrun.
- Pending bits with irq_en cleared stay pending but are not arbitrated until re-enabled.
- Min re-grant spacing: ack -> next irq=1 is 3 cycles (GAP, IDLE select, ASSERT).

Decomposition:
- Package btn_irq_pkg: FSM state enum (IDLE, ASSERT, GAP), default NUM_BTN/DEB_CYCLES constants, ID width function.
- Sub-module btn_debounce (one per button, generate loop): sync + polarity + counter + btn_state + press pulse.
- Top holds pend/overrun, round-robin select, FSM.

Test Plan:
- DEB_CYCLES=8, en=4'hF: btn[1] low for 20 cycles -> pend=4'b0010 at edge 11; irq=1, irq_id=1 one cycle later; ack -> pend=0, irq=0.
- btn[2] low for 5 cycles then released -> btn_state, pend, irq stay 0.
- btn[0] and btn[3] pressed same cycle, last_grant=3 after reset -> grant id 0, ack, 1-cycle GAP, grant id 3, ack -> pend=0.
- Press btn[1] twice (with release) before ack -> overrun=4'b0010, pend[1]=1. ovr_clr -> overrun=0.
- irq_en=4'b1011, press btn[2] -> pend stays 0, irq stays 0; set irq_en[2] afterwards -> still no irq (event discarded).
- Assert rst_n=0 mid-ASSERT with pend=4'b0101 -> irq, pend, overrun all 0 immediately (async). After release, no irq until new presses.
